// File: rtl/sel_button_counter_pkg.sv
// Shared definitions for the pushbutton-to-select-code front end of the
// 4-bit selection decoder.
package sel_button_counter_pkg;

  // Select code width seen by the decoder, and the default top code (1..10 -> 0..9).
  localparam int SEL_W       = 4;
  localparam int SEL_MAX_DEF = 9;

  // Debounce lengths: ~2.5 ms at 100 MHz for silicon, a few cycles for simulation.
  localparam int DEBOUNCE_SYN = 250000;
  localparam int DEBOUNCE_SIM = 4;

  typedef logic [SEL_W-1:0] sel_t;

  // What the select counter is asked to do in a given cycle.
  typedef enum logic [1:0] {
    CMD_HOLD = 2'd0,
    CMD_UP   = 2'd1,
    CMD_DOWN = 2'd2
  } cmd_e;

  // Coincident up and down events cancel each other out.
  function automatic cmd_e decode_cmd(input logic up, input logic dn);
    if (up && !dn) return CMD_UP;
    if (dn && !up) return CMD_DOWN;
    return CMD_HOLD;
  endfunction

endpackage

// File: rtl/sel_button_counter_btn.sv
// One pushbutton conditioner: 2-FF synchronizer, counter debouncer and a
// single-cycle pulse on the rising edge of the debounced level.
module btn_debounce
  import sel_button_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SYN
) (
  input  logic Clk_i,
  input  logic Rst_n_i,
  input  logic Btn_i,
  output logic Stable_o,
  output logic Press_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button level into the clock domain.
  // NOTE: non-blocking assignments in clocked blocks so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the
  // two synchronizer stages into one.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= Btn_i;
      sync2 <= sync1;
    end
  end

  // Flip the stable level only after DEBOUNCE_CYCLES consecutive differing samples;
  // any return to the stable level restarts the count.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed copy of the stable level for rising-edge detection.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) stable_q <= 1'b0;
    else          stable_q <= stable;
  end

  assign Stable_o = stable;
  assign Press_o  = stable & ~stable_q;

endmodule

// File: rtl/sel_button_counter.sv
// Turns the up/down pushbuttons into the 0..SEL_MAX select code for the
// selection decoder, with a one-cycle pulse whenever the code moves.
module sel_button_counter
  import sel_button_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SYN,
  parameter int SEL_MAX         = SEL_MAX_DEF,
  parameter int WRAP            = 0
) (
  input  logic             Clk_i,
  input  logic             Rst_n_i,
  input  logic             BtnUp_i,
  input  logic             BtnDn_i,
  output logic [SEL_W-1:0] Sel_o,
  output logic             Changed_o
);

  localparam sel_t SEL_TOP = sel_t'(SEL_MAX);

  logic up_stable;
  logic up_press;
  logic dn_stable;
  logic dn_press;
  logic unused_stable;
  sel_t sel_q;
  sel_t sel_d;
  logic changed_q;
  cmd_e cmd;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
    .Clk_i    (Clk_i),
    .Rst_n_i  (Rst_n_i),
    .Btn_i    (BtnUp_i),
    .Stable_o (up_stable),
    .Press_o  (up_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dn (
    .Clk_i    (Clk_i),
    .Rst_n_i  (Rst_n_i),
    .Btn_i    (BtnDn_i),
    .Stable_o (dn_stable),
    .Press_o  (dn_press)
  );

  // Only the press pulses drive the counter; the levels are left for other users.
  assign unused_stable = up_stable ^ dn_stable;

  assign cmd = decode_cmd(up_press, dn_press);

  // Next select code: step, saturate or wrap at the ends of 0..SEL_MAX.
  // NOTE: sel_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_d = sel_q;
    case (cmd)
      CMD_UP:   sel_d = (sel_q == SEL_TOP) ? ((WRAP != 0) ? '0 : SEL_TOP) : sel_q + 1'b1;
      CMD_DOWN: sel_d = (sel_q == '0) ? ((WRAP != 0) ? SEL_TOP : '0) : sel_q - 1'b1;
      default:  sel_d = sel_q;
    endcase
  end

  // Select register and its change flag, which rises together with the new code.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      sel_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      changed_q <= (sel_d != sel_q);
    end
  end

  assign Sel_o     = sel_q;
  assign Changed_o = changed_q;

endmodule

// File: doc/sel_button_counter.md
Name: sel_button_counter

Overview:
- Upstream stage of the 4-bit selection decoder: turns two raw pushbuttons (up/down) into the 4-bit select code 0..9 that the decoder maps to values 1..10.
- Per-button 2-FF synchronizer, counter-based debouncer and press-edge detector, feeding a saturating (or optionally wrapping) select counter.
- Sel_o drives the decoder's select input directly and is never outside 0..SEL_MAX.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive cycles a synchronized level must differ from the stable level before the stable level flips (>=1; 4 in simulation)
- SEL_MAX, 9, highest select code produced (<=15)
- WRAP, 0, 0 = saturate at 0 and SEL_MAX; 1 = wrap SEL_MAX->0 on up and 0->SEL_MAX on down

Ports:
- Clk_i  input  1  system clock, all logic on rising edge
- Rst_n_i  input  1  reset, asynchronous, active-low
- BtnUp_i  input  1  raw up button, active-high, asynchronous, bouncy
- BtnDn_i  input  1  raw down button, active-high, asynchronous, bouncy
- Sel_o  output  4  select code to decoder, 0..SEL_MAX
- Changed_o  output  1  one-cycle pulse, high the cycle after Sel_o changes value

Behaviour:
- Reset (Rst_n_i low, asynchronous): Sel_o=0, Changed_o=0, sync flops=0, stable levels=0, debounce counters=0. All state is held while Rst_n_i is low. Release is synchronous to Clk_i via normal flop behaviour.
- Synchronizer: two flops per button. The raw level reaches sync2 on the 2nd edge after it becomes stable.
- Debouncer, per button, counter width clog2(DEBOUNCE_CYCLES+1):
  - If sync2 == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= sync2 and counter <= 0.
  - Else counter <= counter+1.
  - Any bounce back to the stable level before the flip restarts the count from 0.
  - The release is debounced identically.
- Press event: combinational stable & ~stable_q, where stable_q is stable delayed one cycle. It is one cycle wide and occurs on the rising stable edge only; release never produces an event.
- Latency: a clean press first sampled at edge 1 flips stable at edge DEBOUNCE_CYCLES+2. Sel_o updates at edge DEBOUNCE_CYCLES+3. Changed_o is high for the cycle following that edge.
- Counter update on each clock edge:
  - Up event only: Sel_o <= (Sel_o==SEL_MAX) ? (WRAP ? 0 : SEL_MAX) : Sel_o+1.
  - Down event only: Sel_o <= (Sel_o==0) ? (WRAP ? SEL_MAX : 0) : Sel_o-1.
  - Both events in the same cycle: no change.
  - No event: hold.
- Changed_o is registered: high only if Sel_o actually changed. Saturated presses give Changed_o=0.
- Holding a button produces exactly one event; there is no auto-repeat.
- Reset mid-debounce discards the partial count. A button held through reset release must be debounced anew, and registers as a press DEBOUNCE_CYCLES+3 edges later because stable restarts at 0.

Decomposition:
- Shared package: SEL_W=4, default SEL_MAX=9, DEBOUNCE_CYCLES simulation/synthesis defaults.
- Sub-module btn_debounce (sync + debounce + rising-edge pulse; ports Clk_i, Rst_n_i, Btn_i, Stable_o, Press_o), instantiated twice.
- The top holds the select counter and Changed_o.

Test Plan:
1. Reset with DEBOUNCE_CYCLES=4 -> Sel_o=0, Changed_o=0. Hold BtnUp_i high from edge 1 -> Sel_o=1 exactly at edge 7, Changed_o high for one cycle, then Sel_o stays 1 while held.
2. BtnUp_i glitches high 3 cycles, low 1, high 3, low (never 4 stable cycles) -> Sel_o stays 0, Changed_o never asserts.
3. Ten clean up presses from 0 with WRAP=0 -> Sel_o steps 1..9 then stays 9 on the 10th press with Changed_o=0. Repeat with WRAP=1 -> 10th press gives Sel_o=0.
4. Down press at Sel_o=0 -> WRAP=0 holds 0 with no Changed_o; WRAP=1 gives Sel_o=9 with Changed_o pulse.
5. BtnUp_i and BtnDn_i rise on the same edge at Sel_o=5 -> both events coincide, Sel_o stays 5, Changed_o=0.
6. Sel_o=3, up button held, Rst_n_i pulsed low mid-hold -> Sel_o=0 immediately (asynchronous), then Sel_o=1 at edge 7 after reset release while still held.
